ps2_key_tracker: RTL

Scan-code parser between the PS/2 byte receiver and the game control FSM. Consumes the receiver's byte stream (data + one-cycle valid strobe), tracks the E0 extended and F0 break prefixes, and maintains a held level plus a one-cycle press pulse for Enter, Left arrow and Right arrow. Typematic repeats never re-pulse. Partial sequences are abandoned after a timeout.

---
 rtl/ps2_key_tracker.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code parser: follows E0/F0 prefixes and keeps held levels plus
// one-cycle press pulses for Enter, Left and Right; stale partial sequences time out.
module ps2_key_tracker #(
  parameter logic [7:0] ENTER_CODE     = 8'h5A,
  parameter logic [7:0] LEFT_CODE      = 8'h6B,
  parameter logic [7:0] RIGHT_CODE     = 8'h74,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       EnterHeld,
  output logic       LeftHeld,
  output logic       RightHeld,
  output logic       EnterPress,
  output logic       LeftPress,
  output logic       RightPress,
  output logic       seq_error
);

  localparam logic [7:0] EXT_PREFIX = 8'hE0;
  localparam logic [7:0] BRK_PREFIX = 8'hF0;
  localparam logic [7:0] SELF_TEST  = 8'hAA;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  // Key vectors: bit 0 Enter, bit 1 Left, bit 2 Right.
  logic [2:0]       held_reg, held_next;
  logic [2:0]       press_reg, press_next;
  logic             err_reg, err_next;

  logic       strobe;
  logic       is_prefix;
  logic       timeout;
  logic [2:0] make_vec;
  logic [2:0] brk_vec;
  logic       clear_all;

  assign strobe    = received_data_en;
  assign is_prefix = (received_data == EXT_PREFIX) || (received_data == BRK_PREFIX);
  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign timeout   = (state_reg != IDLE) && !strobe &&
                     (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      held_reg  <= '0;
      press_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      held_reg  <= held_next;
      press_reg <= press_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (strobe) begin
      unique case (state_reg)
        IDLE: begin
          if (received_data == EXT_PREFIX)      state_next = EXT;
          else if (received_data == BRK_PREFIX) state_next = BRK;
        end
        EXT: begin
          if (received_data == BRK_PREFIX)      state_next = EXT_BRK;
          else if (received_data == EXT_PREFIX) state_next = EXT;
          else                                  state_next = IDLE;
        end
        BRK:     state_next = IDLE;
        EXT_BRK: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end else if (timeout) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    if (strobe || (state_reg == IDLE) || timeout) cnt_next = '0;
  end

  always_comb begin
    make_vec   = '0;
    brk_vec    = '0;
    clear_all  = 1'b0;
    err_next   = timeout;
    if (strobe) begin
      unique case (state_reg)
        IDLE: begin
          make_vec[0] = (received_data == ENTER_CODE);
          clear_all   = (received_data == SELF_TEST);
        end
        EXT: begin
          make_vec[1] = (received_data == LEFT_CODE);
          make_vec[2] = (received_data == RIGHT_CODE);
        end
        BRK: begin
          brk_vec[0] = (received_data == ENTER_CODE);
          err_next   = is_prefix;
        end
        EXT_BRK: begin
          brk_vec[1] = (received_data == LEFT_CODE);
          brk_vec[2] = (received_data == RIGHT_CODE);
          err_next   = is_prefix;
        end
        default: err_next = 1'b0;
      endcase
    end
    // Typematic repeats re-assert make but only a 0->1 edge pulses.
    press_next = make_vec & ~held_reg;
    held_next  = clear_all ? 3'b000 : ((held_reg | make_vec) & ~brk_vec);
  end

  assign EnterHeld  = held_reg[0];
  assign LeftHeld   = held_reg[1];
  assign RightHeld  = held_reg[2];
  assign EnterPress = press_reg[0];
  assign LeftPress  = press_reg[1];
  assign RightPress = press_reg[2];
  assign seq_error  = err_reg;

endmodule
